// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: default geometry, colour layout and the
// rectangle-writer state encoding, shared with the display-side buffer.
package fb_pkg;

   localparam int FB_H_WIDTH    = 200;
   localparam int FB_V_WIDTH    = 600;
   localparam int FB_R_DEPTH    = 2;
   localparam int FB_G_DEPTH    = 2;
   localparam int FB_B_DEPTH    = 2;
   localparam int FB_COLOR_BITS = FB_R_DEPTH + FB_G_DEPTH + FB_B_DEPTH;
   localparam int FB_H_BITS     = 9;
   localparam int FB_V_BITS     = 10;
   localparam int FB_ADDR_BITS  = 17;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fb_state_e;

   typedef logic [FB_COLOR_BITS-1:0] fb_color_t;

   typedef struct packed {
      logic [FB_R_DEPTH-1:0] r;
      logic [FB_G_DEPTH-1:0] g;
      logic [FB_B_DEPTH-1:0] b;
   } fb_pixel_t;

   function automatic fb_pixel_t fb_unpack_color(input fb_color_t c);
      return fb_pixel_t'(c);
   endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster walker for one rectangle: x/y position and the running row base
// address, with an end-of-line wrap and a last-pixel flag.
module fb_raster_counter #(
   parameter int H_WIDTH   = 200,
   parameter int H_BITS    = 9,
   parameter int V_BITS    = 10,
   parameter int ADDR_BITS = 17
) (
   input  logic                 clk,
   input  logic                 load_i,
   input  logic [H_BITS-1:0]    x0_i,
   input  logic [V_BITS-1:0]    y0_i,
   input  logic [H_BITS:0]      x_end_i,
   input  logic [V_BITS:0]      y_end_i,
   input  logic [ADDR_BITS-1:0] row_base_i,
   input  logic                 adv_i,
   output logic [H_BITS-1:0]    x_o,
   output logic [ADDR_BITS-1:0] row_base_o,
   output logic                 last_o
);

   localparam logic [ADDR_BITS-1:0] H_STEP = ADDR_BITS'(H_WIDTH);

   logic [H_BITS-1:0]    x0_q, x_q;
   logic [V_BITS-1:0]    y_q;
   logic [H_BITS:0]      x_end_q;
   logic [V_BITS:0]      y_end_q;
   logic [ADDR_BITS-1:0] row_base_q;
   logic                 eol;

   // End bounds are exclusive, so the last column/line is one below them.
   assign eol        = (({1'b0, x_q} + 1'b1) == x_end_q);
   assign last_o     = eol && (({1'b0, y_q} + 1'b1) == y_end_q);
   assign x_o        = x_q;
   assign row_base_o = row_base_q;

   always_ff @(posedge clk) begin
      if (load_i) begin
         x0_q       <= x0_i;
         x_q        <= x0_i;
         y_q        <= y0_i;
         x_end_q    <= x_end_i;
         y_end_q    <= y_end_i;
         row_base_q <= row_base_i;
      end else if (adv_i) begin
         if (eol) begin
            x_q        <= x0_q;
            y_q        <= y_q + 1'b1;
            row_base_q <= row_base_q + H_STEP;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine: clips an accepted command to the frame and streams
// one registered pixel write per allowed cycle in raster order.
module fb_rect_writer
   import fb_pkg::*;
#(
   parameter int H_WIDTH   = FB_H_WIDTH,
   parameter int V_WIDTH   = FB_V_WIDTH,
   parameter int R_DEPTH   = FB_R_DEPTH,
   parameter int G_DEPTH   = FB_G_DEPTH,
   parameter int B_DEPTH   = FB_B_DEPTH,
   parameter int H_BITS    = FB_H_BITS,
   parameter int V_BITS    = FB_V_BITS,
   parameter int ADDR_BITS = FB_ADDR_BITS
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [H_BITS-1:0]                    cmd_x0,
   input  logic [V_BITS-1:0]                    cmd_y0,
   input  logic [H_BITS-1:0]                    cmd_w,
   input  logic [V_BITS-1:0]                    cmd_h,
   input  logic [R_DEPTH+G_DEPTH+B_DEPTH-1:0]   cmd_color,
   input  logic                                 wr_allow,
   output logic                                 wr_en,
   output logic [ADDR_BITS-1:0]                 wr_addr,
   output logic [R_DEPTH+G_DEPTH+B_DEPTH-1:0]   wr_data,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 clipped
);

   localparam int COLOR_BITS = R_DEPTH + G_DEPTH + B_DEPTH;
   localparam logic [H_BITS:0]      H_LIM  = (H_BITS+1)'(H_WIDTH);
   localparam logic [V_BITS:0]      V_LIM  = (V_BITS+1)'(V_WIDTH);
   localparam logic [ADDR_BITS-1:0] H_STEP = ADDR_BITS'(H_WIDTH);

   fb_state_e             state_q, state_d;
   logic                  accept, issue, empty, last_pix;
   logic                  clip_x, clip_y;
   logic [H_BITS:0]       x_sum, x_end;
   logic [V_BITS:0]       y_sum, y_end;
   logic [H_BITS-1:0]     x_cur;
   logic [ADDR_BITS-1:0]  row_base_cur, row_base_init, wr_addr_d;
   logic                  wr_en_q, done_q, clipped_q;
   logic [ADDR_BITS-1:0]  wr_addr_q;
   logic [COLOR_BITS-1:0] wr_data_q;

   assign accept = cmd_valid && cmd_ready;
   assign issue  = (state_q == ST_FILL) && wr_allow;

   // Sums carry one extra bit so x0+w / y0+h can never wrap.
   always_comb begin
      x_sum  = {1'b0, cmd_x0} + {1'b0, cmd_w};
      y_sum  = {1'b0, cmd_y0} + {1'b0, cmd_h};
      clip_x = (x_sum > H_LIM);
      clip_y = (y_sum > V_LIM);
      x_end  = clip_x ? H_LIM : x_sum;
      y_end  = clip_y ? V_LIM : y_sum;
      empty  = (cmd_w == '0) || (cmd_h == '0) ||
               ({1'b0, cmd_x0} >= H_LIM) || ({1'b0, cmd_y0} >= V_LIM);
   end

   assign row_base_init = ADDR_BITS'(cmd_y0) * H_STEP;
   assign wr_addr_d     = row_base_cur + ADDR_BITS'(x_cur);

   fb_raster_counter #(
      .H_WIDTH   (H_WIDTH),
      .H_BITS    (H_BITS),
      .V_BITS    (V_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_raster (
      .clk        (clk),
      .load_i     (accept),
      .x0_i       (cmd_x0),
      .y0_i       (cmd_y0),
      .x_end_i    (x_end),
      .y_end_i    (y_end),
      .row_base_i (row_base_init),
      .adv_i      (issue),
      .x_o        (x_cur),
      .row_base_o (row_base_cur),
      .last_o     (last_pix)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = empty ? ST_DONE : ST_FILL;
         ST_FILL: if (issue && last_pix) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // done trails the DONE state by a register, so hold off acceptance for it too.
   always_comb begin
      cmd_ready = (state_q == ST_IDLE) && !done_q && !rst;
      busy      = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         clipped_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= issue;
         done_q  <= (state_q == ST_DONE);
         if (accept) begin
            clipped_q <= empty || clip_x || clip_y;
            wr_data_q <= cmd_color;
         end
         if (issue) wr_addr_q <= wr_addr_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign done    = done_q;
   assign clipped = clipped_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Randomised self-checking bench for fb_rect_writer against a queue-based
// model of the clipped rectangle's raster-order write list.
module tb_fb_rect_writer;

   localparam int HW = 200;
   localparam int VW = 600;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, wr_allow, wr_en, busy, done, clipped;
   logic [8:0]  cmd_x0, cmd_w;
   logic [9:0]  cmd_y0, cmd_h;
   logic [5:0]  cmd_color, wr_data;
   logic [16:0] wr_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fb_rect_writer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x0    (cmd_x0),
      .cmd_y0    (cmd_y0),
      .cmd_w     (cmd_w),
      .cmd_h     (cmd_h),
      .cmd_color (cmd_color),
      .wr_allow  (wr_allow),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .clipped   (clipped)
   );

   task automatic chk_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode: 0 allow always on, 1 random allow, 2 random allow plus junk
   // commands held on the bus while busy, 3 fixed allow table then on.
   task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                          input int color, input int mode, input string name);
      int  q[$];
      int  xe, ye, exp_n, budget, writes, addr_err, data_err, gap_err;
      int  done_cnt, done_cyc, last_wr, exp_done;
      bit  empty, clip, prev_allow, a;
      bit  tab[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      xe    = (x0 + w > HW) ? HW : x0 + w;
      ye    = (y0 + h > VW) ? VW : y0 + h;
      empty = (w == 0) || (h == 0) || (x0 >= HW) || (y0 >= VW);
      clip  = empty || (x0 + w > HW) || (y0 + h > VW);
      if (!empty)
         for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
               q.push_back(y * HW + x);
      exp_n  = q.size();
      budget = 4 * exp_n + 64;
      writes = 0; addr_err = 0; data_err = 0; gap_err = 0;
      done_cnt = 0; done_cyc = 0; last_wr = 0;

      @(negedge clk);
      chk_eq({name, " ready_idle"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_x0    = 9'(x0);
      cmd_y0    = 10'(y0);
      cmd_w     = 9'(w);
      cmd_h     = 10'(h);
      cmd_color = 6'(color);
      wr_allow  = 1'b0;
      prev_allow = 1'b0;

      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (n == 1) chk_eq({name, " busy"}, busy, 1);
         if (wr_en) begin
            writes++;
            last_wr = n;
            if (!prev_allow) gap_err++;
            if (q.size() == 0) addr_err++;
            else begin
               if (int'(wr_addr) != q[0]) addr_err++;
               void'(q.pop_front());
            end
            if (int'(wr_data) != color) data_err++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = n;
            chk_eq({name, " clipped"}, clipped, clip);
            chk_eq({name, " ready_at_done"}, cmd_ready, 0);
         end
         if (done_cnt > 0 && n == done_cyc + 1) begin
            chk_eq({name, " ready_after_done"}, cmd_ready, 1);
            break;
         end
         if (mode == 2 && done_cnt == 0) begin
            cmd_valid = 1'b1;
            cmd_x0    = 9'($urandom);
            cmd_y0    = 10'($urandom);
            cmd_w     = 9'($urandom);
            cmd_h     = 10'($urandom);
            cmd_color = 6'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         case (mode)
            0:       a = 1'b1;
            3:       a = (n <= 7) ? tab[n-1] : 1'b1;
            default: a = ($urandom_range(0, 3) != 0);
         endcase
         wr_allow   = a;
         prev_allow = a;
      end
      cmd_valid = 1'b0;
      wr_allow  = 1'b0;

      exp_done = empty ? 2 : last_wr + 1;
      chk_eq({name, " write_count"}, writes, exp_n);
      chk_eq({name, " addr_errors"}, addr_err, 0);
      chk_eq({name, " data_errors"}, data_err, 0);
      chk_eq({name, " write_without_allow"}, gap_err, 0);
      chk_eq({name, " done_pulses"}, done_cnt, 1);
      chk_eq({name, " done_cycle"}, done_cyc, exp_done);
   endtask

   task automatic reset_mid_fill();
      int wr, dn, n;
      wr = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_x0 = 9'd5; cmd_y0 = 10'd7; cmd_w = 9'd10; cmd_h = 10'd1;
      cmd_color = 6'h33;
      wr_allow  = 1'b1;
      for (n = 0; n < 20 && wr < 3; n++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (wr_en) wr++;
      end
      chk_eq("rst_pre_writes", wr, 3);
      rst = 1'b1;
      @(negedge clk);
      chk_eq("rst_wr_en", wr_en, 0);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_ready_during", cmd_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_eq("rst_ready_after", cmd_ready, 1);
      wr = 0; dn = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (wr_en) wr++;
         if (done) dn++;
      end
      chk_eq("rst_no_more_writes", wr, 0);
      chk_eq("rst_no_done", dn, 0);
      wr_allow = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; wr_allow = 1'b0;
      cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      repeat (2) @(negedge clk);
      chk_eq("reset_ready", cmd_ready, 0);
      chk_eq("reset_wr_en", wr_en, 0);
      chk_eq("reset_done", done, 0);
      chk_eq("reset_busy", busy, 0);
      chk_eq("reset_clipped", clipped, 0);
      chk_eq("reset_wr_addr", wr_addr, 0);
      chk_eq("reset_wr_data", wr_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_eq("ready_after_reset", cmd_ready, 1);

      run_cmd(3, 2, 2, 2, 'h2A, 0, "basic");
      run_cmd(198, 599, 5, 4, 'h15, 0, "corner_clip");
      run_cmd(10, 10, 0, 5, 'h3F, 0, "empty_w0");
      run_cmd(250, 10, 4, 5, 'h01, 1, "empty_x250");
      run_cmd(0, 0, 4, 1, 'h07, 3, "allow_table");
      run_cmd(0, 450, 200, 150, 'h11, 0, "bottom_band");
      reset_mid_fill();
      run_cmd(20, 30, 3, 2, 'h22, 0, "after_reset");
      for (int i = 0; i < 14; i++)
         run_cmd($urandom_range(0, 215), $urandom_range(0, 615),
                 $urandom_range(0, 30), $urandom_range(0, 12),
                 $urandom_range(0, 63), $urandom_range(1, 2), "random");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
